nr_quotient_unit: RTL and testbench

//  Division stage directly downstream of the Newton-Raphson reciprocal block.
//  - Consumes a 16-bit unsigned integer dividend N and the reciprocal R = 1/D in fixed-point [4:-19] (unsigned, 24 b).
//  - Produces the quotient Q = N*R in fixed-point [15:-8] (unsigned, 24 b), with saturation and an overflow flag.
//  - Uses an iterative shift-add multiplier and valid/ready handshakes on both sides.

---
 rtl/nr_pkg.sv | 22 ++
 rtl/nr_seq_mul.sv | 53 +++++
 rtl/nr_quotient_unit.sv | 94 +++++++++
 tb/tb_nr_quotient_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nr_pkg.sv
// rtl/nr_pkg.sv - shared types and constants for the NR quotient stage
// Fixed-point views, FSM state encoding and saturation constant.
package nr_pkg;
  localparam int N_W    = 16;
  localparam int R_INT  = 5;
  localparam int R_FRAC = 19;
  localparam int Q_FRAC = 8;
  localparam int Q_W    = N_W + Q_FRAC;
  localparam int ACC_W  = N_W + R_INT + R_FRAC;

  localparam logic [Q_W-1:0] Q_SAT = 24'hFFFFFF;

  typedef logic [4:-19] fxp_5_19_t;
  typedef logic [15:-8] fxp_16_8_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN,
    HOLD
  } nr_q_state_e;
endpackage

// File: rtl/nr_seq_mul.sv
// rtl/nr_seq_mul.sv - serial 16x24 shift-add multiplier with start/last
// One multiplier bit per cycle; o_last marks the cycle of the final partial product.
module nr_seq_mul
  import nr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [N_W-1:0]   i_a,
  input  fxp_5_19_t        i_b,
  output logic [ACC_W-1:10] o_acc_hi,
  output logic             o_last
);
  logic [N_W-1:0]   r_a;
  logic [23:0]      r_b;
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_cnt;
  logic             r_run;
  logic [ACC_W-1:0] w_addend;

  always_comb begin
    w_addend = '0;
    if (r_a[r_cnt]) begin
      w_addend = {{(ACC_W-24){1'b0}}, r_b} << r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= r_acc + w_addend;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) begin
        r_run <= 1'b0;
      end
    end
  end

  // Bits below the half-LSB of the quotient never influence the result.
  assign o_acc_hi = r_acc[ACC_W-1:10];
  assign o_last   = r_run && (r_cnt == 4'd15);
endmodule

// File: rtl/nr_quotient_unit.sv
// rtl/nr_quotient_unit.sv - quotient Q = N*R with saturation, after the NR reciprocal
// QUOTIENT_ROUND_EN selects round-half-up instead of truncation in FIN.
module nr_quotient_unit
  import nr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   dividend,
  input  logic [23:0]      recip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   quotient,
  output logic             overflow,
  output logic             busy
);
`ifdef QUOTIENT_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  nr_q_state_e r_state;
  logic        r_rzero;
  fxp_16_8_t   r_quotient;
  logic        r_overflow;
  logic        r_out_valid;

  logic              w_start;
  logic [ACC_W-1:10] w_acc_hi;
  logic              w_last;
  logic [29:0]       w_t;
  logic              w_sat;

  assign w_start = (r_state == IDLE) && in_valid;

  nr_seq_mul u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_a      (dividend),
    .i_b      (recip),
    .o_acc_hi (w_acc_hi),
    .o_last   (w_last)
  );

  // acc >> (R_FRAC-Q_FRAC) plus optional half-LSB; one spare bit catches the round carry.
  assign w_t   = {1'b0, w_acc_hi[ACC_W-1:11]} + {29'd0, w_acc_hi[10] & ROUND_EN};
  assign w_sat = r_rzero || (w_t[29:24] != 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rzero     <= 1'b0;
      r_quotient  <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rzero <= (recip == 24'd0);
            r_state <= MUL;
          end
        end
        MUL: begin
          if (w_last) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_quotient  <= w_sat ? Q_SAT : w_t[23:0];
          r_overflow  <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_nr_quotient_unit.sv
// tb/tb_nr_quotient_unit.sv - self-checking bench for nr_quotient_unit
// Arithmetic reference model, directed literal cases, then randomized transactions.
module tb_nr_quotient_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [23:0] recip = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] quotient;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [23:0] exp_q = '0;
  logic        exp_ov = 1'b0;
  logic        exp_vld = 1'b0;
  logic        seen = 1'b0;

  nr_quotient_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .recip     (recip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Q = floor(N*R / 2^11) (+ half-LSB when rounding); saturate past 24 bits or on R==0.
  function automatic void model(input logic [15:0] n, input logic [23:0] r,
                                output logic [23:0] q, output logic ov);
    longint p;
    longint t;
    p = longint'(n) * longint'(r);
    t = p / 2048;
`ifdef QUOTIENT_ROUND_EN
    t = t + ((p / 1024) % 2);
`endif
    if (r == 24'd0 || t > 64'h0000_0000_00FF_FFFF) begin
      q  = 24'hFFFFFF;
      ov = 1'b1;
    end else begin
      q  = t[23:0];
      ov = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_vld) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - acc_cyc), 32'd17);
          seen = 1'b1;
        end
        chk("quotient", 32'(quotient), 32'(exp_q));
        chk("overflow", 32'(overflow), 32'(exp_ov));
      end
    end
  end

  task automatic do_txn(input logic [15:0] n, input logic [23:0] r, input int bp,
                        input logic use_lit, input logic [23:0] lq, input logic lo);
    int k;
    logic [23:0] q_hold;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    dividend = n;
    recip    = r;
    in_valid = 1'b1;
    model(n, r, exp_q, exp_ov);
    seen    = 1'b0;
    exp_vld = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    recip    = 24'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    q_hold = quotient;
    if (use_lit) begin
      chk("literal_quotient", 32'(quotient), 32'(lq));
      chk("literal_overflow", 32'(overflow), 32'(lo));
    end
    for (int i = 0; i < bp; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", 32'(quotient), 32'(q_hold));
      in_valid = 1'($urandom);
      dividend = 16'($urandom);
      recip    = 24'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_vld   = 1'b0;
    chk("out_valid_cleared", 32'(out_valid), 32'd0);
    chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [23:0] r;
    #1;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    do_txn(16'd100, 24'h020000, 0, 1'b1, 24'h001900, 1'b0);
`ifdef QUOTIENT_ROUND_EN
    do_txn(16'd3, 24'h02AAAA, 0, 1'b1, 24'h000100, 1'b0);
`else
    do_txn(16'd3, 24'h02AAAA, 0, 1'b1, 24'h0000FF, 1'b0);
`endif
    do_txn(16'hFFFF, 24'h100000, 1, 1'b1, 24'hFFFFFF, 1'b1);
    do_txn(16'hFFFF, 24'h080000, 0, 1'b1, 24'hFFFF00, 1'b0);
    do_txn(16'd7, 24'h000000, 2, 1'b1, 24'hFFFFFF, 1'b1);
    do_txn(16'd0, 24'h0ABCDE, 0, 1'b1, 24'h000000, 1'b0);
    do_txn(16'd100, 24'h020000, 5, 1'b1, 24'h001900, 1'b0);

    // Abort mid-multiply: MUL has processed cnt 0..7 when reset lands.
    dividend = 16'hFFFF;
    recip    = 24'h080000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n   = 1'b0;
    exp_vld = 1'b0;
    #1;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 32'(in_ready), 32'd1);
    do_txn(16'd10, 24'h040000, 0, 1'b1, 24'h000500, 1'b0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       r = 24'd0;
        1:       r = 24'($urandom);
        default: r = 24'($urandom) >> $urandom_range(4, 14);
      endcase
      do_txn(16'($urandom), r, int'($urandom_range(0, 3)), 1'b0, 24'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
